ext_out_uart_tx: RTL and testbench
==================================

// Module: ext_out_uart_tx
// PURPOSE
//  Downstream consumer of the RISC processor's OutExtWorld1 8-bit output port. Detects each
//  new value written to the port and queues it in a small FIFO. Serializes queued bytes onto an
//  8N1 UART line so bench/board logic can observe the processor's output stream.
// PARAMETERS
//  CLKS_PER_BIT  8  clk cycles per UART bit; legal range 2..65535
//  FIFO_DEPTH    4  byte queue entries; must be a power of 2, >=2
// PORTS
//  clk          in   1  system clock; all logic on posedge
//  Reset_n      in   1  asynchronous, active-low reset
//  OutExtWorld  in   8  processor output port level (held between writes)
//  tx_en        in   1  1 = capture port changes; 0 = ignore changes, drain FIFO only
//  clear_ovf    in   1  synchronous clear of overflow flag
//  uart_tx      out  1  serial line, idle high
//  busy         out  1  1 while a frame is on the line (state != IDLE)
//  fifo_empty   out  1  FIFO holds 0 entries
//  fifo_full    out  1  FIFO holds FIFO_DEPTH entries
//  overflow     out  1  sticky: a captured byte was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (async, Reset_n=0): uart_tx=1, busy=0, fifo_empty=1, fifo_full=0, overflow=0,
//   last_val=8'h00, FIFO pointers/count=0, state=IDLE, bit/baud counters=0. Applies immediately,
//   mid-frame included; the partial frame is abandoned and the line returns high at once.
//  Change capture: each cycle with tx_en=1 and OutExtWorld!=last_val -> push OutExtWorld and
//   last_val<=OutExtWorld. Entry visible (fifo_empty=0) the following cycle.
//  Full FIFO on capture: byte dropped, overflow<=1, last_val still updated (no retry).
//  Simultaneous push+pop while full: pop frees the slot in the same cycle; push accepted,
//   no overflow. Push into empty FIFO is not popped until the next cycle (pop uses registered
//   count). clear_ovf and a same-cycle overflow event: set wins.
//  tx_en=0: no captures, last_val frozen; queued bytes still transmit.
//  FIFO: circular buffer, rd/wr pointers log2(FIFO_DEPTH) bits, wrap naturally modulo depth;
//   count register 0..FIFO_DEPTH drives full/empty.
//  TX FSM, each bit lasts exactly CLKS_PER_BIT cycles (baud counter counts CLKS_PER_BIT-1..0):
//   IDLE : uart_tx=1; if !fifo_empty -> pop into shift reg, go START next cycle.
//   START: uart_tx=0 -> DATA.
//   DATA : uart_tx=shift[0], LSB first, 8 bits via bit counter 0..7 -> STOP (or PARITY).
//   STOP : uart_tx=1 -> IDLE.
//  Frame = 10*CLKS_PER_BIT cycles; back-to-back frames separated by exactly 1 IDLE cycle.
//  First start-bit edge occurs 2 cycles after the port change (capture, then pop).
//  busy is registered with state; deasserts in the IDLE cycle after STOP.
// CONFIGURATION
//  EXT_OUT_PARITY_EN defined: PARITY state inserted between DATA and STOP, driving even parity
//   (^byte) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT cycles.
//  Not defined: 8N1 only, no PARITY state or parity logic synthesized.
// TESTING (CLKS_PER_BIT=8, FIFO_DEPTH=4)
//  1 Reset_n=0 for 3 cycles, OutExtWorld=8'h00 -> uart_tx=1, busy=0, fifo_empty=1, overflow=0.
//  2 OutExtWorld 00->01 with tx_en=1 -> start bit 2 cycles later, then bits 1,0,0,0,0,0,0,0 of
//    8 cycles each, stop high; busy low at cycle 82 after change; line idle afterwards.
//  3 Write A5,3C,FF,10 on consecutive cycles -> four frames in order, each 80 cycles, 1-cycle
//    gap between them; no overflow.
//  4 Write 6 distinct values on consecutive cycles during a frame -> fifo_full=1, overflow=1,
//    extra bytes dropped; clear_ovf=1 pulse -> overflow=0.
//  5 Reset_n=0 at cycle 30 of a frame -> uart_tx=1 within the same cycle (async), FIFO empty;
//    after release no residual frame, OutExtWorld=00 produces no transmission.
//  6 EXT_OUT_PARITY_EN, write 8'h07 -> 11-bit frame, parity bit=1 (three ones); 8'h03 -> 0.

Source files
------------

// File: rtl/ext_out_uart_tx.sv
// Captures changes on the processor output port into a small FIFO and sends them as 8N1 UART frames.
// Define EXT_OUT_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module ext_out_uart_tx #(
   parameter int CLKS_PER_BIT = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       Reset_n,
   input  logic [7:0] OutExtWorld,
   input  logic       tx_en,
   input  logic       clear_ovf,
   output logic       uart_tx,
   output logic       busy,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
   localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);

`ifdef EXT_OUT_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state;
   logic [7:0]       last_val;
   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [7:0]       shift;
   logic [2:0]       bit_cnt;
   logic [15:0]      baud_cnt;
   logic             capture;
   logic             pop;
   logic             push;
   logic             drop;
`ifdef EXT_OUT_PARITY_EN
   logic             parity_bit;
`endif

   // Pop looks at the registered count, so a byte pushed this cycle waits one cycle.
   assign capture    = tx_en && (OutExtWorld != last_val);
   assign pop        = (state == IDLE) && (count != '0);
   assign push       = capture && ((count != CNT_FULL) || pop);
   assign drop       = capture && !push;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CNT_FULL);

   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         last_val <= 8'h00;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (capture)
            last_val <= OutExtWorld;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= OutExtWorld;
   end

   // Every state holds for CLKS_PER_BIT cycles; uart_tx is registered on the transition into each bit.
   always_ff @(posedge clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         uart_tx  <= 1'b1;
         busy     <= 1'b0;
         shift    <= 8'h00;
         bit_cnt  <= 3'd0;
         baud_cnt <= 16'd0;
`ifdef EXT_OUT_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               uart_tx <= 1'b1;
               if (pop) begin
                  shift    <= mem[rd_ptr];
`ifdef EXT_OUT_PARITY_EN
                  parity_bit <= ^mem[rd_ptr];
`endif
                  state    <= START;
                  uart_tx  <= 1'b0;
                  busy     <= 1'b1;
                  baud_cnt <= BAUD_LAST;
               end
            end
            START: begin
               if (baud_cnt == 16'd0) begin
                  state    <= DATA;
                  uart_tx  <= shift[0];
                  shift    <= shift >> 1;
                  bit_cnt  <= 3'd0;
                  baud_cnt <= BAUD_LAST;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            DATA: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_LAST;
                  if (bit_cnt == 3'd7) begin
`ifdef EXT_OUT_PARITY_EN
                     state   <= PARITY;
                     uart_tx <= parity_bit;
`else
                     state   <= STOP;
                     uart_tx <= 1'b1;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                     uart_tx <= shift[0];
                     shift   <= shift >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`ifdef EXT_OUT_PARITY_EN
            PARITY: begin
               if (baud_cnt == 16'd0) begin
                  state    <= STOP;
                  uart_tx  <= 1'b1;
                  baud_cnt <= BAUD_LAST;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_cnt == 16'd0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               uart_tx <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ext_out_uart_tx.sv
// Scoreboard bench for ext_out_uart_tx: bytes expected on the line are queued when driven
// and checked against frames decoded from uart_tx.
module tb_ext_out_uart_tx;

   localparam int CPB = 8;
`ifdef EXT_OUT_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_LEN = FRAME_BITS * CPB;

   logic       clk;
   logic       Reset_n;
   logic [7:0] OutExtWorld;
   logic       tx_en;
   logic       clear_ovf;
   logic       uart_tx;
   logic       busy;
   logic       fifo_empty;
   logic       fifo_full;
   logic       overflow;

   int         total_checks = 0;
   int         bad_checks   = 0;
   int         cycle        = 0;
   int         last_start   = 0;
   logic [7:0] sb_q[$];

   ext_out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .Reset_n    (Reset_n),
      .OutExtWorld(OutExtWorld),
      .tx_en      (tx_en),
      .clear_ovf  (clear_ovf),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total_checks++;
      if (actual !== expected) begin
         bad_checks++;
         $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] value, input bit accepted);
      @(negedge clk);
      OutExtWorld = value;
      if (accepted)
         sb_q.push_back(value);
   endtask

   task automatic waitUntil(input int target);
      while (cycle < target)
         @(negedge clk);
   endtask

   // Starts sampling at the current negedge; decodes one frame and scores it against the queue.
   task automatic receiveFrame(input string tag);
      logic [FRAME_LEN-1:0] smp;
      logic [7:0] data;
      logic [7:0] exp_byte;
      logic       busy_end;
      int         waited;
      int         unstable;
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      if (uart_tx !== 1'b0) begin
         checkOutput({tag, "_start_seen"}, uart_tx, 0);
         return;
      end
      last_start = cycle;
      busy_end = 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) begin
         smp[i]   = uart_tx;
         busy_end = busy;
         @(negedge clk);
      end
      checkOutput({tag, "_busy_last"}, busy_end, 1);
      checkOutput({tag, "_busy_after"}, busy, 0);
      unstable = 0;
      for (int b = 0; b < FRAME_BITS; b++)
         for (int k = 1; k < CPB; k++)
            if (smp[b*CPB+k] !== smp[b*CPB]) unstable++;
      checkOutput({tag, "_bit_stable"}, unstable, 0);
      checkOutput({tag, "_stop"}, smp[(FRAME_BITS-1)*CPB + CPB/2], 1);
      for (int j = 0; j < 8; j++)
         data[j] = smp[(j+1)*CPB + CPB/2];
      checkOutput({tag, "_sb_pending"}, (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         exp_byte = sb_q.pop_front();
         checkOutput({tag, "_data"}, data, exp_byte);
`ifdef EXT_OUT_PARITY_EN
         checkOutput({tag, "_parity"}, smp[9*CPB + CPB/2], ^exp_byte);
`endif
      end
   endtask

   initial begin
      int d;
      int lows;
      int empties;
      Reset_n     = 1'b0;
      OutExtWorld = 8'h00;
      tx_en       = 1'b0;
      clear_ovf   = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_line", uart_tx, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_empty", fifo_empty, 1);
      checkOutput("rst_full", fifo_full, 0);
      checkOutput("rst_ovf", overflow, 0);
      Reset_n = 1'b1;
      tx_en   = 1'b1;

      // Single byte: latency and frame shape
      applyStimulus(8'h01, 1);
      @(negedge clk);
      checkOutput("t2_line_cap", uart_tx, 1);
      checkOutput("t2_visible", fifo_empty, 0);
      @(negedge clk);
      checkOutput("t2_start_edge", uart_tx, 0);
      checkOutput("t2_busy", busy, 1);
      receiveFrame("t2");
      lows = 0;
      repeat (20) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      checkOutput("t2_idle_after", lows, 0);

      // Back-to-back frames
      fork
         begin
            applyStimulus(8'hA5, 1);
            applyStimulus(8'h3C, 1);
            applyStimulus(8'hFF, 1);
            applyStimulus(8'h10, 1);
         end
         begin
            int prev;
            receiveFrame("t3_f0");
            prev = last_start;
            for (int f = 1; f < 4; f++) begin
               receiveFrame($sformatf("t3_f%0d", f));
               checkOutput($sformatf("t3_gap%0d", f), last_start - prev, FRAME_LEN + 1);
               prev = last_start;
            end
         end
      join
      checkOutput("t3_ovf", overflow, 0);
      checkOutput("t3_empty", fifo_empty, 1);

      // Overflow, clear, and push coinciding with pop while full
      fork
         begin
            applyStimulus(8'h55, 1);
            d = cycle;
            waitUntil(d + 10);
            applyStimulus(8'h11, 1);
            applyStimulus(8'h22, 1);
            applyStimulus(8'h33, 1);
            applyStimulus(8'h44, 1);
            applyStimulus(8'h66, 0);
            applyStimulus(8'h77, 0);
            @(negedge clk);
            checkOutput("t4_full", fifo_full, 1);
            checkOutput("t4_ovf_set", overflow, 1);
            clear_ovf = 1'b1;
            @(negedge clk);
            clear_ovf = 1'b0;
            checkOutput("t4_ovf_clr", overflow, 0);
            checkOutput("t4_still_full", fifo_full, 1);
            waitUntil(d + 2 + FRAME_LEN - 1);
            applyStimulus(8'h88, 1);
            @(negedge clk);
            checkOutput("t4_pushpop_ovf", overflow, 0);
            checkOutput("t4_pushpop_full", fifo_full, 1);
         end
         begin
            for (int f = 0; f < 6; f++)
               receiveFrame($sformatf("t4_f%0d", f));
         end
      join
      checkOutput("t4_empty", fifo_empty, 1);

      // Asynchronous reset mid-frame
      applyStimulus(8'h5A, 0);
      d = cycle;
      applyStimulus(8'hA6, 0);
      waitUntil(d + 2 + 30);
      checkOutput("t5_pre_line", uart_tx, 0);
      checkOutput("t5_pre_busy", busy, 1);
      Reset_n = 1'b0;
      #1;
      checkOutput("t5_async_line", uart_tx, 1);
      checkOutput("t5_async_busy", busy, 0);
      checkOutput("t5_async_empty", fifo_empty, 1);
      OutExtWorld = 8'h00;
      repeat (2) @(negedge clk);
      Reset_n = 1'b1;
      lows = 0;
      empties = 0;
      repeat (200) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
         if (fifo_empty === 1'b1) empties++;
      end
      checkOutput("t5_no_residual", lows, 0);
      checkOutput("t5_stay_empty", empties, 200);

      // tx_en low freezes last_val; re-enabling captures the pending difference
      tx_en = 1'b0;
      applyStimulus(8'h77, 0);
      lows = 0;
      empties = 0;
      repeat (20) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
         if (fifo_empty === 1'b1) empties++;
      end
      checkOutput("t6_no_tx", lows, 0);
      checkOutput("t6_no_capture", empties, 20);
      tx_en = 1'b1;
      sb_q.push_back(8'h77);
      receiveFrame("t6");

`ifdef EXT_OUT_PARITY_EN
      applyStimulus(8'h07, 1);
      receiveFrame("par07");
      applyStimulus(8'h03, 1);
      receiveFrame("par03");
`endif

      checkOutput("sb_drained", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
